// File: rtl/debounce_bank.sv
// rtl/debounce_bank.sv - multi-channel symmetric debouncer with press/release pulses
// Two-flop synchroniser per channel feeding a stability counter gated by sample_en.
module debounce_bank #(
  parameter int CHANNELS   = 4,
  parameter int STABLE_CNT = 16,
  parameter int COUNT_W    = 5,
  parameter int INIT_LEVEL = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_en,
  input  logic [CHANNELS-1:0] buttons,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse
);

  localparam logic [CHANNELS-1:0] INIT_VEC = {CHANNELS{INIT_LEVEL != 0}};
  localparam logic [COUNT_W-1:0]  LAST_CNT = COUNT_W'(STABLE_CNT - 1);

  logic [CHANNELS-1:0] sync1;
  logic [CHANNELS-1:0] sync2;
  logic [COUNT_W-1:0]  cnt [CHANNELS];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1         <= INIT_VEC;
      sync2         <= INIT_VEC;
      level         <= INIT_VEC;
      press_pulse   <= '0;
      release_pulse <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1         <= buttons;
      sync2         <= sync1;
      press_pulse   <= '0;
      release_pulse <= '0;
      if (sample_en) begin
        for (int i = 0; i < CHANNELS; i++) begin
          // Any sample agreeing with the current level restarts stability timing.
          if (sync2[i] == level[i]) begin
            cnt[i] <= '0;
          end else if (cnt[i] == LAST_CNT) begin
            level[i]         <= sync2[i];
            cnt[i]           <= '0;
            press_pulse[i]   <= sync2[i];
            release_pulse[i] <= ~sync2[i];
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end
  end

endmodule
